// File: rtl/wasm_alu_seq_pkg.sv
// Shared types and constants for the stack-machine ALU sequencer:
// opcode values, ALU control codes, FSM state encoding and trap codes.
package wasm_alu_seq_pkg;

  localparam int ST_WIDTH_DEF = 32;
  localparam int DEPTH_W_DEF  = 10;

  // WASM i32 numeric opcodes handled by the sequencer
  localparam logic [7:0] OP_SELECT   = 8'h1B;
  localparam logic [7:0] OP_I32_EQZ  = 8'h45;
  localparam logic [7:0] OP_I32_EQ   = 8'h46;
  localparam logic [7:0] OP_I32_NE   = 8'h47;
  localparam logic [7:0] OP_I32_LT_S = 8'h48;
  localparam logic [7:0] OP_I32_LT_U = 8'h49;
  localparam logic [7:0] OP_I32_GT_S = 8'h4A;
  localparam logic [7:0] OP_I32_GT_U = 8'h4B;
  localparam logic [7:0] OP_I32_LE_S = 8'h4C;
  localparam logic [7:0] OP_I32_LE_U = 8'h4D;
  localparam logic [7:0] OP_I32_GE_S = 8'h4E;
  localparam logic [7:0] OP_I32_GE_U = 8'h4F;
  localparam logic [7:0] OP_I32_ADD  = 8'h6A;
  localparam logic [7:0] OP_I32_SUB  = 8'h6B;
  localparam logic [7:0] OP_I32_AND  = 8'h71;
  localparam logic [7:0] OP_I32_OR   = 8'h72;
  localparam logic [7:0] OP_I32_SHL  = 8'h74;
  localparam logic [7:0] OP_I32_SHRS = 8'h75;
  localparam logic [7:0] OP_I32_SHRU = 8'h76;
  localparam logic [7:0] OP_I32_ROTL = 8'h77;
  localparam logic [7:0] OP_I32_ROTR = 8'h78;

  // ALU control codes
  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_AND    = 5'h02;
  localparam logic [4:0] ALU_OR     = 5'h03;
  localparam logic [4:0] ALU_SELECT = 5'h04;
  localparam logic [4:0] ALU_EQZ    = 5'h05;
  localparam logic [4:0] ALU_EQ     = 5'h06;
  localparam logic [4:0] ALU_LT_U   = 5'h07;
  localparam logic [4:0] ALU_GT_U   = 5'h08;
  localparam logic [4:0] ALU_LE_U   = 5'h09;
  localparam logic [4:0] ALU_GE_U   = 5'h0A;
  localparam logic [4:0] ALU_LT_S   = 5'h0B;
  localparam logic [4:0] ALU_GT_S   = 5'h0C;
  localparam logic [4:0] ALU_LE_S   = 5'h0D;
  localparam logic [4:0] ALU_GE_S   = 5'h0E;
  localparam logic [4:0] ALU_NE     = 5'h0F;
  localparam logic [4:0] ALU_SHL    = 5'h10;
  localparam logic [4:0] ALU_SHR_S  = 5'h11;
  localparam logic [4:0] ALU_SHR_U  = 5'h12;
  localparam logic [4:0] ALU_ROTL   = 5'h13;
  localparam logic [4:0] ALU_ROTR   = 5'h14;

  // Trap codes
  localparam logic [1:0] TRAP_NONE      = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL   = 2'b01;
  localparam logic [1:0] TRAP_UNDERFLOW = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_PUSH = 3'd4,
    S_TRAP = 3'd5
  } state_e;

endpackage

// File: rtl/wasm_alu_seq_if.sv
// Bundle of decoder, operand-stack and ALU signals around the sequencer.
// master = the sequencer side, slave = the decoder/stack/ALU side.
interface wasm_alu_seq_if #(
  parameter int ST_WIDTH = 32,
  parameter int DEPTH_W  = 10
);
  logic                op_valid;
  logic                op_ready;
  logic [7:0]          op_code;
  logic [DEPTH_W-1:0]  st_depth;
  logic                st_pop;
  logic [ST_WIDTH-1:0] st_pop_data;
  logic                st_push;
  logic [ST_WIDTH-1:0] st_push_data;
  logic                st_push_rdy;
  logic [ST_WIDTH-1:0] alu_a;
  logic [ST_WIDTH-1:0] alu_b;
  logic [ST_WIDTH-1:0] alu_c;
  logic [4:0]          alu_ctrl;
  logic [ST_WIDTH-1:0] alu_result;
  logic                done;
  logic                trap;
  logic [1:0]          trap_code;

  modport master (
    input  op_valid, op_code, st_depth, st_pop_data, st_push_rdy, alu_result,
    output op_ready, st_pop, st_push, st_push_data, alu_a, alu_b, alu_c,
           alu_ctrl, done, trap, trap_code
  );

  modport slave (
    output op_valid, op_code, st_depth, st_pop_data, st_push_rdy, alu_result,
    input  op_ready, st_pop, st_push, st_push_data, alu_a, alu_b, alu_c,
           alu_ctrl, done, trap, trap_code
  );
endinterface

// File: rtl/wasm_alu_seq_op_decode.sv
// Combinational opcode decoder: legality, ALU control, operand count and
// whether the op is a shift/rotate (its count operand gets masked to 5 bits).
module wasm_alu_seq_op_decode
  import wasm_alu_seq_pkg::*;
(
  input  logic [7:0] op_code,
  output logic       legal,
  output logic [4:0] alu_ctrl,
  output logic [1:0] n_ops,
  output logic       is_shift
);

  // opcode lookup; anything not listed is illegal with zero operands
  always_comb begin
    legal    = 1'b1;
    alu_ctrl = ALU_ADD;
    n_ops    = 2'd2;
    is_shift = 1'b0;
    case (op_code)
      OP_SELECT:   begin alu_ctrl = ALU_SELECT; n_ops = 2'd3; end
      OP_I32_EQZ:  begin alu_ctrl = ALU_EQZ;    n_ops = 2'd1; end
      OP_I32_EQ:   alu_ctrl = ALU_EQ;
      OP_I32_NE:   alu_ctrl = ALU_NE;
      OP_I32_LT_S: alu_ctrl = ALU_LT_S;
      OP_I32_LT_U: alu_ctrl = ALU_LT_U;
      OP_I32_GT_S: alu_ctrl = ALU_GT_S;
      OP_I32_GT_U: alu_ctrl = ALU_GT_U;
      OP_I32_LE_S: alu_ctrl = ALU_LE_S;
      OP_I32_LE_U: alu_ctrl = ALU_LE_U;
      OP_I32_GE_S: alu_ctrl = ALU_GE_S;
      OP_I32_GE_U: alu_ctrl = ALU_GE_U;
      OP_I32_ADD:  alu_ctrl = ALU_ADD;
      OP_I32_SUB:  alu_ctrl = ALU_SUB;
      OP_I32_AND:  alu_ctrl = ALU_AND;
      OP_I32_OR:   alu_ctrl = ALU_OR;
      OP_I32_SHL:  begin alu_ctrl = ALU_SHL;   is_shift = 1'b1; end
      OP_I32_SHRS: begin alu_ctrl = ALU_SHR_S; is_shift = 1'b1; end
      OP_I32_SHRU: begin alu_ctrl = ALU_SHR_U; is_shift = 1'b1; end
      OP_I32_ROTL: begin alu_ctrl = ALU_ROTL;  is_shift = 1'b1; end
      OP_I32_ROTR: begin alu_ctrl = ALU_ROTR;  is_shift = 1'b1; end
      default: begin
        legal = 1'b0;
        n_ops = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/wasm_alu_seq.sv
// Stack-machine ALU sequencer: accepts one decoded opcode, pops 1-3
// operands, drives the ALU, registers the result and pushes it back.
module wasm_alu_seq
  import wasm_alu_seq_pkg::*;
#(
  parameter int ST_WIDTH = ST_WIDTH_DEF,
  parameter int DEPTH_W  = DEPTH_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  wasm_alu_seq_if.master bus
);

  state_e              state;
  logic                op_ready_q;
  logic                st_pop_q;
  logic                st_push_q;
  logic [ST_WIDTH-1:0] push_data_q;
  logic [ST_WIDTH-1:0] alu_a_q, alu_b_q, alu_c_q;
  logic [4:0]          alu_ctrl_q;
  logic                trap_q;
  logic [1:0]          trap_code_q;

  logic [1:0]          n_ops_q;
  logic [1:0]          pop_cnt;   // pops issued so far for this op
  logic [1:0]          cap_idx;   // next operand slot to fill
  logic                is_shift_q;
  logic                pop_d;     // a pop was issued last cycle, data is on st_pop_data
  logic                push_fire;

  logic                dec_legal;
  logic [4:0]          dec_ctrl;
  logic [1:0]          dec_n;
  logic                dec_shift;

  wasm_alu_seq_op_decode u_dec (
    .op_code  (bus.op_code),
    .legal    (dec_legal),
    .alu_ctrl (dec_ctrl),
    .n_ops    (dec_n),
    .is_shift (dec_shift)
  );

  assign push_fire = (state == S_PUSH) && bus.st_push_rdy;

  assign bus.op_ready     = op_ready_q;
  assign bus.st_pop       = st_pop_q;
  assign bus.st_push      = st_push_q;
  assign bus.st_push_data = push_data_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_c        = alu_c_q;
  assign bus.alu_ctrl     = alu_ctrl_q;
  assign bus.trap         = trap_q;
  assign bus.trap_code    = trap_code_q;
  // done marks the push handshake itself, so it follows st_push_rdy directly
  assign bus.done         = push_fire;

  // main FSM: accept/decode, pop sequencing, execute, push handshake, trap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_ready_q  <= 1'b1;
      st_pop_q    <= 1'b0;
      st_push_q   <= 1'b0;
      push_data_q <= '0;
      alu_ctrl_q  <= '0;
      trap_q      <= 1'b0;
      trap_code_q <= TRAP_NONE;
      n_ops_q     <= '0;
      pop_cnt     <= '0;
      is_shift_q  <= 1'b0;
      pop_d       <= 1'b0;
    end else begin
      pop_d <= st_pop_q;
      case (state)
        S_IDLE: begin
          if (bus.op_valid) begin
            if (!dec_legal) begin
              state       <= S_TRAP;
              op_ready_q  <= 1'b0;
              trap_q      <= 1'b1;
              trap_code_q <= TRAP_ILLEGAL;
            end else if (bus.st_depth < DEPTH_W'(dec_n)) begin
              state       <= S_TRAP;
              op_ready_q  <= 1'b0;
              trap_q      <= 1'b1;
              trap_code_q <= TRAP_UNDERFLOW;
            end else begin
              state      <= S_POP;
              op_ready_q <= 1'b0;
              st_pop_q   <= 1'b1;
              pop_cnt    <= 2'd1;
              n_ops_q    <= dec_n;
              is_shift_q <= dec_shift;
              alu_ctrl_q <= dec_ctrl;
            end
          end
        end
        S_POP: begin
          if (pop_cnt == n_ops_q) begin
            st_pop_q <= 1'b0;
            state    <= S_WAIT;
          end else begin
            pop_cnt <= pop_cnt + 2'd1;
          end
        end
        S_WAIT: state <= S_EXEC;
        S_EXEC: begin
          push_data_q <= bus.alu_result;
          st_push_q   <= 1'b1;
          state       <= S_PUSH;
        end
        S_PUSH: begin
          if (bus.st_push_rdy) begin
            st_push_q  <= 1'b0;
            op_ready_q <= 1'b1;
            alu_ctrl_q <= '0;
            state      <= S_IDLE;
          end
        end
        S_TRAP: begin
          trap_q      <= 1'b0;
          trap_code_q <= TRAP_NONE;
          op_ready_q  <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // operand capture: each popped word lands in the next slot a, b, c;
  // a shift count is reduced to its low 5 bits as it is captured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_c_q <= '0;
      cap_idx <= '0;
    end else if (push_fire) begin
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_c_q <= '0;
      cap_idx <= '0;
    end else if (pop_d) begin
      case (cap_idx)
        2'd0: alu_a_q <= is_shift_q ? {{(ST_WIDTH-5){1'b0}}, bus.st_pop_data[4:0]}
                                    : bus.st_pop_data;
        2'd1: alu_b_q <= bus.st_pop_data;
        default: alu_c_q <= bus.st_pop_data;
      endcase
      cap_idx <= cap_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_wasm_alu_seq.sv
// Directed bench for wasm_alu_seq: a queue models the operand stack and a
// small behavioural ALU supplies alu_result; checks are immediate assertions.
module tb_wasm_alu_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pop_count;
  logic [31:0] stk[$];

  wasm_alu_seq_if #(.ST_WIDTH(32), .DEPTH_W(10)) bus ();

  wasm_alu_seq #(.ST_WIDTH(32), .DEPTH_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // operand stack: popped word appears the cycle after st_pop
  always @(posedge clk) begin
    if (bus.st_pop) begin
      if (stk.size() > 0) begin
        bus.st_pop_data <= stk[$];
        stk.pop_back();
      end else begin
        bus.st_pop_data <= 32'hDEAD_BEEF;
      end
      pop_count <= pop_count + 1;
    end
  end

  // reference ALU: A = top of stack, B = next, C = third
  always_comb begin
    bus.alu_result = 32'h0;
    case (bus.alu_ctrl)
      5'h00: bus.alu_result = bus.alu_b + bus.alu_a;
      5'h01: bus.alu_result = bus.alu_b - bus.alu_a;
      5'h04: bus.alu_result = (bus.alu_a != 0) ? bus.alu_c : bus.alu_b;
      5'h05: bus.alu_result = {31'b0, bus.alu_a == 32'h0};
      5'h0B: bus.alu_result = {31'b0, $signed(bus.alu_b) < $signed(bus.alu_a)};
      5'h10: bus.alu_result = bus.alu_b << bus.alu_a[4:0];
      default: bus.alu_result = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer one opcode, then wait (bounded) for the done pulse
  task automatic run_op(input logic [7:0] code, input int depth, output int dcyc,
                        output logic [31:0] data, output logic [4:0] ctrl,
                        output logic [31:0] a, output int pops);
    int p0;
    p0   = pop_count;
    dcyc = -1;
    data = '0;
    ctrl = '0;
    a    = '0;
    bus.op_code  = code;
    bus.st_depth = 10'(depth);
    bus.op_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      bus.op_valid = 1'b0;
      bus.op_code  = 8'h6A;  // must not disturb the latched op
      if (bus.done) begin
        dcyc = i;
        data = bus.st_push_data;
        ctrl = bus.alu_ctrl;
        a    = bus.alu_a;
        break;
      end
    end
    pops = pop_count - p0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int dcyc, pops, p0, got;
    logic [31:0] data, a;
    logic [4:0]  ctrl;

    checks = 0;
    errors = 0;
    pop_count = 0;
    rst_n = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code = 8'h00;
    bus.st_depth = '0;
    bus.st_push_rdy = 1'b1;
    bus.st_pop_data = '0;
    step();
    step();
    chk("reset_op_ready", 32'(bus.op_ready), 1);
    chk("reset_st_pop", 32'(bus.st_pop), 0);
    chk("reset_st_push", 32'(bus.st_push), 0);
    chk("reset_done_trap", {30'b0, bus.done, bus.trap}, 0);
    chk("reset_alu_ctrl", 32'(bus.alu_ctrl), 0);
    chk("reset_push_data", bus.st_push_data, 0);
    rst_n = 1'b1;
    step();

    // i32.sub: 10 - 3
    stk.push_back(32'd10);
    stk.push_back(32'd3);
    run_op(8'h6B, 2, dcyc, data, ctrl, a, pops);
    chk("sub_data", data, 7);
    chk("sub_done_cycle", 32'(dcyc), 5);
    chk("sub_pops", 32'(pops), 2);
    chk("sub_ctrl", 32'(ctrl), 32'h01);
    chk("sub_op_ready_T6", 32'(bus.op_ready), 1);
    chk("sub_push_low", 32'(bus.st_push), 0);

    // select with cond == 0 -> val2
    stk.push_back(32'hAA);
    stk.push_back(32'hBB);
    stk.push_back(32'h0);
    run_op(8'h1B, 3, dcyc, data, ctrl, a, pops);
    chk("sel0_data", data, 32'hBB);
    chk("sel0_done_cycle", 32'(dcyc), 6);
    chk("sel0_pops", 32'(pops), 3);

    // select with cond != 0 -> val1
    stk.push_back(32'hAA);
    stk.push_back(32'hBB);
    stk.push_back(32'h5);
    run_op(8'h1B, 3, dcyc, data, ctrl, a, pops);
    chk("sel5_data", data, 32'hAA);

    // i32.shl with count 33 -> count masked to 1
    stk.push_back(32'd1);
    stk.push_back(32'd33);
    run_op(8'h74, 2, dcyc, data, ctrl, a, pops);
    chk("shl_alu_a", a, 1);
    chk("shl_data", data, 2);
    chk("shl_ctrl", 32'(ctrl), 32'h10);

    // i32.lt_s: -1 < 1
    stk.push_back(32'hFFFF_FFFF);
    stk.push_back(32'd1);
    run_op(8'h48, 2, dcyc, data, ctrl, a, pops);
    chk("lt_s_data", data, 1);
    chk("lt_s_done_cycle", 32'(dcyc), 5);

    // underflow trap: add with one entry
    stk.push_back(32'h55);
    p0 = pop_count;
    bus.op_code = 8'h6A;
    bus.st_depth = 10'd1;
    bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    chk("uflow_trap", 32'(bus.trap), 1);
    chk("uflow_code", 32'(bus.trap_code), 2);
    chk("uflow_no_pop", 32'(bus.st_pop), 0);
    chk("uflow_not_ready", 32'(bus.op_ready), 0);
    step();
    chk("uflow_ready_after", 32'(bus.op_ready), 1);
    chk("uflow_trap_pulse", 32'(bus.trap), 0);
    chk("uflow_pops", 32'(pop_count - p0), 0);
    stk.delete();

    // illegal opcode
    bus.op_code = 8'h99;
    bus.st_depth = 10'd5;
    bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
    chk("illegal_trap", 32'(bus.trap), 1);
    chk("illegal_code", 32'(bus.trap_code), 1);
    step();
    chk("illegal_ready_after", 32'(bus.op_ready), 1);

    // backpressure: eqz of 0 with st_push_rdy low for 4 cycles
    stk.push_back(32'h0);
    p0 = pop_count;
    bus.st_push_rdy = 1'b0;
    bus.op_code = 8'h45;
    bus.st_depth = 10'd1;
    bus.op_valid = 1'b1;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      bus.op_valid = 1'b0;
      if (bus.st_push) begin
        got = i;
        break;
      end
    end
    chk("bp_push_cycle", 32'(got), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_push_held", 32'(bus.st_push), 1);
      chk("bp_data_stable", bus.st_push_data, 1);
      chk("bp_no_done", 32'(bus.done), 0);
      bus.op_valid = 1'b1;  // ignored outside IDLE
      bus.op_code = 8'h6A;
      bus.st_depth = 10'd5;
      step();
    end
    bus.op_valid = 1'b0;
    bus.st_push_rdy = 1'b1;
    #1;
    chk("bp_done_on_rdy", 32'(bus.done), 1);
    step();
    chk("bp_ready_after", 32'(bus.op_ready), 1);
    chk("bp_push_dropped", 32'(bus.st_push), 0);
    step();
    chk("bp_no_new_pop", 32'(bus.st_pop), 0);
    chk("bp_pops", 32'(pop_count - p0), 1);

    // reset while in PUSH
    stk.push_back(32'h7);
    bus.st_push_rdy = 1'b0;
    bus.op_code = 8'h45;
    bus.st_depth = 10'd1;
    bus.op_valid = 1'b1;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      bus.op_valid = 1'b0;
      if (bus.st_push) begin
        got = i;
        break;
      end
    end
    chk("rst_reached_push", 32'(got), 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.st_push_rdy = 1'b1;
    #1;
    chk("rst_mid_op_ready", 32'(bus.op_ready), 1);
    chk("rst_mid_push", 32'(bus.st_push), 0);
    chk("rst_mid_done", 32'(bus.done), 0);
    chk("rst_mid_trap", 32'(bus.trap), 0);
    chk("rst_mid_ctrl", 32'(bus.alu_ctrl), 0);
    chk("rst_mid_data", bus.st_push_data, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
